// File: rtl/csr_pkg.sv
// csr_pkg: machine-mode CSR addresses, mstatus layout, writeback request and trap cause encodings.
package csr_pkg;
    localparam int XLEN = 64;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [3:0] {
        EXC_IADDR_MISALIGN = 4'd0,
        EXC_ILLEGAL_INSN   = 4'd2,
        EXC_BREAKPOINT     = 4'd3,
        EXC_LADDR_MISALIGN = 4'd4,
        EXC_SADDR_MISALIGN = 4'd6,
        EXC_ECALL_U        = 4'd8,
        EXC_ECALL_M        = 4'd11
    } exc_e;

    typedef enum logic [1:0] {TRINT, SWINT, EXINT} irq_e;

    function automatic logic [3:0] irq_code(irq_e i);
        return i == TRINT ? 4'd7 : i == SWINT ? 4'd3 : 4'd11;
    endfunction

    typedef struct packed {
        logic [50:0] wpri_hi;
        logic [1:0]  mpp;
        logic [2:0]  wpri_mid;
        logic        mpie;
        logic [2:0]  wpri_lo;
        logic        mie;
        logic [2:0]  wpri_low;
    } mstatus_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            w_valid;
        logic [11:0]     wa;
        logic [XLEN-1:0] wd;
        logic            is_mret;
        logic            is_exception;
        exc_e            m_exception;
        logic            is_interrupt;
        irq_e            m_interrupt;
    } csr_input_t;
endpackage

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: IDLE/REDIR redirect FSM, request priority and redirect target / trap cause selection.
module csr_trap_ctrl
    import csr_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            w_valid_i,
    input  logic            mret_i,
    input  logic            exc_i,
    input  exc_e            exc_code_i,
    input  logic            irq_i,
    input  irq_e            irq_sel_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            idle_o,
    output logic            accept_o,
    output logic [XLEN-1:0] cause_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    typedef enum logic {IDLE, REDIR} state_e;

    state_e          state_q;
    logic [3:0]      icode;
    logic [XLEN-1:0] base, vec_off, target;

    always_comb begin
        icode   = irq_code(irq_sel_i);
        base    = {mtvec_i[XLEN-1:2], 2'b00};
        vec_off = mtvec_i[1:0] == 2'b01 ? {{(XLEN-6){1'b0}}, icode, 2'b00} : '0;
        cause_o = exc_i ? {1'b0, {(XLEN-5){1'b0}}, exc_code_i} : {1'b1, {(XLEN-5){1'b0}}, icode};
        target  = w_valid_i ? pc_i + XLEN'(4) :
                  mret_i    ? mepc_i :
                  exc_i     ? base :
                  irq_i     ? base + vec_off : pc_i + XLEN'(4);
    end

    assign idle_o   = state_q == IDLE;
    assign accept_o = idle_o & valid_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else if (accept_o) begin
            state_q          <= REDIR;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= target;
        end else begin
            state_q          <= IDLE;
            redirect_valid_o <= 1'b0;
        end
    end
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, counters, interrupt pending logic; trap/mret sequencing via csr_trap_ctrl.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [XLEN-1:0] HARTID      = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  csr_input_t      csr_input,
    input  logic            instret,
    input  logic            timer_irq,
    input  logic            sw_irq,
    input  logic            ext_irq,
    input  logic [11:0]     ra,
    output logic [XLEN-1:0] rd,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trint,
    output logic            swint,
    output logic            exint,
    output logic [1:0]      priv_mode
);
    logic            idle, accept, wr, mret, trap;
    logic [XLEN-1:0] cause;
    logic            st_mie_q, st_mpie_q, mtip_q, msip_q, meip_q;
    logic [1:0]      mpp_q;
    logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mscratch_q;
    logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    mstatus_t        mstatus;
    logic [XLEN-1:0] mip;

    csr_trap_ctrl u_trap (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_i          (csr_input.valid),
        .pc_i             (csr_input.pc),
        .w_valid_i        (csr_input.w_valid),
        .mret_i           (csr_input.is_mret),
        .exc_i            (csr_input.is_exception),
        .exc_code_i       (csr_input.m_exception),
        .irq_i            (csr_input.is_interrupt),
        .irq_sel_i        (csr_input.m_interrupt),
        .mtvec_i          (mtvec_q),
        .mepc_i           (mepc_q),
        .idle_o           (idle),
        .accept_o         (accept),
        .cause_o          (cause),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    // Only one action per accepted request: write > mret > exception > interrupt.
    always_comb begin
        wr         = accept & csr_input.w_valid;
        mret       = accept & ~csr_input.w_valid & csr_input.is_mret;
        trap       = accept & ~csr_input.w_valid & ~csr_input.is_mret &
                     (csr_input.is_exception | csr_input.is_interrupt);
        mcycle_d   = wr && csr_input.wa == CSR_MCYCLE ? csr_input.wd : mcycle_q + XLEN'(1);
        minstret_d = wr && csr_input.wa == CSR_MINSTRET ? csr_input.wd : minstret_q + XLEN'(instret);
        mstatus      = '0;
        mstatus.mie  = st_mie_q;
        mstatus.mpie = st_mpie_q;
        mstatus.mpp  = mpp_q;
        mip = {{(XLEN-12){1'b0}}, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
        rd  = ra == CSR_MSTATUS  ? XLEN'(mstatus) :
              ra == CSR_MIE      ? mie_q :
              ra == CSR_MTVEC    ? mtvec_q :
              ra == CSR_MSCRATCH ? mscratch_q :
              ra == CSR_MEPC     ? mepc_q :
              ra == CSR_MCAUSE   ? mcause_q :
              ra == CSR_MIP      ? mip :
              ra == CSR_MCYCLE   ? mcycle_q :
              ra == CSR_MINSTRET ? minstret_q :
              ra == CSR_MHARTID  ? HARTID : '0;
    end

    assign trint = idle & st_mie_q & mie_q[7] & mtip_q;
    assign swint = idle & st_mie_q & mie_q[3] & msip_q;
    assign exint = idle & st_mie_q & mie_q[11] & meip_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mpp_q      <= 2'b00;
            priv_mode  <= 2'b11;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            mtip_q     <= 1'b0;
            msip_q     <= 1'b0;
            meip_q     <= 1'b0;
        end else begin
            mtip_q     <= timer_irq;
            msip_q     <= sw_irq;
            meip_q     <= ext_irq;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            if (wr) begin
                case (csr_input.wa)
                    CSR_MSTATUS: begin
                        st_mie_q  <= csr_input.wd[3];
                        st_mpie_q <= csr_input.wd[7];
                        mpp_q     <= csr_input.wd[12:11];
                    end
                    CSR_MIE:      mie_q      <= csr_input.wd;
                    CSR_MTVEC:    mtvec_q    <= csr_input.wd;
                    CSR_MSCRATCH: mscratch_q <= csr_input.wd;
                    CSR_MEPC:     mepc_q     <= csr_input.wd;
                    CSR_MCAUSE:   mcause_q   <= csr_input.wd;
                    default: ;
                endcase
            end
            if (mret) begin
                st_mie_q  <= st_mpie_q;
                st_mpie_q <= 1'b1;
                priv_mode <= mpp_q;
                mpp_q     <= 2'b00;
            end
            if (trap) begin
                mepc_q    <= csr_input.pc;
                mcause_q  <= cause;
                st_mpie_q <= st_mie_q;
                st_mie_q  <= 1'b0;
                mpp_q     <= priv_mode;
                priv_mode <= 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboarded redirect checks plus direct CSR read-back checks for csr_file.
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [63:0] MTVEC_R = 64'h40;
    localparam logic [63:0] HART    = 64'h5;

    logic        clk = 1'b0;
    logic        reset_n;
    csr_input_t  csr_input;
    logic        instret, timer_irq, sw_irq, ext_irq;
    logic [11:0] ra;
    logic [63:0] rd, redirect_pc;
    logic        redirect_valid, trint, swint, exint;
    logic [1:0]  priv_mode;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    csr_input_t  r;

    csr_file #(.HARTID(HART), .MTVEC_RESET(MTVEC_R)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_input      (csr_input),
        .instret        (instret),
        .timer_irq      (timer_irq),
        .sw_irq         (sw_irq),
        .ext_irq        (ext_irq),
        .ra             (ra),
        .rd             (rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trint          (trint),
        .swint          (swint),
        .exint          (exint),
        .priv_mode      (priv_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [63:0] exp);
        ra = a;
        #1;
        check(tag, rd, exp);
    endtask

    function automatic csr_input_t wr_req(input logic [11:0] a, input logic [63:0] d, input logic [63:0] pc);
        csr_input_t q = '0;
        q.valid = 1'b1; q.w_valid = 1'b1; q.wa = a; q.wd = d; q.pc = pc;
        return q;
    endfunction

    // Drive one request, expect its redirect, check REDIR-cycle outputs, return in IDLE.
    task automatic issue(input csr_input_t q, input logic [63:0] exp_pc);
        csr_input = q;
        sb.push_back(exp_pc);
        step();
        csr_input = '0;
        check("redir_valid", {63'b0, redirect_valid}, 64'd1);
        check("redir_irq_mask", {61'b0, trint, swint, exint}, 64'd0);
        step();
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && redirect_valid === 1'b1) begin
            if (sb.size() == 0) check("unexpected_redirect", redirect_pc, 64'hDEAD_BEEF_DEAD_BEEF);
            else check("redirect_pc", redirect_pc, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; csr_input = '0; instret = 1'b0;
        timer_irq = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0; ra = CSR_MTVEC;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_priv", {62'b0, priv_mode}, 64'd3);
        check("rst_rv", {63'b0, redirect_valid}, 64'd0);
        check("rst_rpc", redirect_pc, 64'd0);
        check("rst_ints", {61'b0, trint, swint, exint}, 64'd0);
        rd_check("rst_mtvec", CSR_MTVEC, MTVEC_R);
        rd_check("rst_mstatus", CSR_MSTATUS, 64'd0);
        rd_check("rst_mcycle", CSR_MCYCLE, 64'd0);
        rd_check("mhartid", CSR_MHARTID, HART);
        rd_check("unimpl_rd", 12'h7C0, 64'd0);
        repeat (10) step();
        rd_check("mcycle_10", CSR_MCYCLE, 64'd10);

        issue(wr_req(CSR_MTVEC, 64'h8000_0100, 64'h8000_0000), 64'h8000_0004);
        rd_check("mtvec_wr", CSR_MTVEC, 64'h8000_0100);
        issue(wr_req(CSR_MHARTID, 64'h99, 64'h8000_0008), 64'h8000_000C);
        rd_check("mhartid_ro", CSR_MHARTID, HART);

        issue(wr_req(CSR_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1000), 64'h1004);
        rd_check("mstatus_mask", CSR_MSTATUS, 64'h1888);
        issue(wr_req(CSR_MSTATUS, 64'h8, 64'h1010), 64'h1014);
        r = '0; r.valid = 1'b1; r.is_exception = 1'b1; r.m_exception = EXC_ECALL_M; r.pc = 64'h8000_0010;
        issue(r, 64'h8000_0100);
        rd_check("exc_mepc", CSR_MEPC, 64'h8000_0010);
        rd_check("exc_mcause", CSR_MCAUSE, 64'd11);
        rd_check("exc_mstatus", CSR_MSTATUS, 64'h1880);
        check("exc_priv", {62'b0, priv_mode}, 64'd3);

        r = wr_req(CSR_MSCRATCH, 64'h1234, 64'h8000_0020);
        r.is_exception = 1'b1; r.m_exception = EXC_ILLEGAL_INSN;
        issue(r, 64'h8000_0024);
        rd_check("prio_mscratch", CSR_MSCRATCH, 64'h1234);
        rd_check("prio_mepc", CSR_MEPC, 64'h8000_0010);

        issue(wr_req(CSR_MTVEC, 64'h8000_0101, 64'h30), 64'h34);
        issue(wr_req(CSR_MSTATUS, 64'h8, 64'h40), 64'h44);
        issue(wr_req(CSR_MIE, 64'h80, 64'h50), 64'h54);
        timer_irq = 1'b1;
        #1 check("trint_lat", {63'b0, trint}, 64'd0);
        step();
        step();
        check("trint_on", {63'b0, trint}, 64'd1);
        check("swint_off", {63'b0, swint}, 64'd0);
        rd_check("mip", CSR_MIP, 64'h80);
        r = '0; r.valid = 1'b1; r.is_interrupt = 1'b1; r.m_interrupt = TRINT; r.pc = 64'h8000_0200;
        issue(r, 64'h8000_011C);
        rd_check("irq_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
        rd_check("irq_mepc", CSR_MEPC, 64'h8000_0200);
        rd_check("irq_mstatus", CSR_MSTATUS, 64'h1880);
        check("irq_trint_off", {63'b0, trint}, 64'd0);

        issue(wr_req(CSR_MSTATUS, 64'h80, 64'h60), 64'h64);
        r = '0; r.valid = 1'b1; r.is_mret = 1'b1; r.pc = 64'h70;
        csr_input = r;
        sb.push_back(64'h8000_0200);
        step();
        check("mret_rv", {63'b0, redirect_valid}, 64'd1);
        check("mret_redir_trint", {63'b0, trint}, 64'd0);
        csr_input = wr_req(CSR_MSCRATCH, 64'hDEAD, 64'h80);
        step();
        csr_input = '0;
        step();
        rd_check("redir_ignored", CSR_MSCRATCH, 64'h1234);
        rd_check("mret_mstatus", CSR_MSTATUS, 64'h88);
        check("mret_priv", {62'b0, priv_mode}, 64'd0);
        check("mret_trint", {63'b0, trint}, 64'd1);

        issue(wr_req(CSR_MIE, 64'h888, 64'h90), 64'h94);
        sw_irq = 1'b1; ext_irq = 1'b1;
        step();
        check("sw_ext_int", {61'b0, trint, swint, exint}, 64'd7);
        timer_irq = 1'b0; sw_irq = 1'b0; ext_irq = 1'b0;
        step();
        check("ints_clear", {61'b0, trint, swint, exint}, 64'd0);

        csr_input = wr_req(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA0);
        sb.push_back(64'hA4);
        step();
        csr_input = '0;
        rd_check("mcycle_max", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        rd_check("mcycle_wrap", CSR_MCYCLE, 64'd0);
        instret = 1'b1;
        csr_input = wr_req(CSR_MINSTRET, 64'h55, 64'hB0);
        sb.push_back(64'hB4);
        step();
        csr_input = '0;
        rd_check("minstret_wr", CSR_MINSTRET, 64'h55);
        step();
        rd_check("minstret_inc", CSR_MINSTRET, 64'h56);
        instret = 1'b0;

        csr_input = wr_req(CSR_MSCRATCH, 64'h77, 64'hC0);
        step();
        csr_input = '0;
        check("pre_rst_rv", {63'b0, redirect_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_rv", {63'b0, redirect_valid}, 64'd0);
        check("rst_mid_rpc", redirect_pc, 64'd0);
        check("rst_mid_priv", {62'b0, priv_mode}, 64'd3);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rd_check("rst_mscratch", CSR_MSCRATCH, 64'd0);
        rd_check("rst2_mtvec", CSR_MTVEC, MTVEC_R);

        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
